// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: next-PC select codes, reset PC
// and the canonical nop encoding.
package mips_pkg;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // sll $0, $0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and register targets.
// All targets are relative to the PC+4 of the instruction currently in ID.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc4_if_i,
  input  logic [31:0] id_pc4_i,
  input  logic [1:0]  npc_sel_i,
  input  logic        br_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] npc_o
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  always_comb begin
    br_target = id_pc4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    j_target  = {id_pc4_i[31:28], imm26_i, 2'b00};
    npc_o     = pc4_if_i;
    unique case (npc_sel_i)
      NPC_PC4: npc_o = pc4_if_i;
      NPC_BR:  npc_o = br_taken_i ? br_target : pc4_if_i;
      NPC_J:   npc_o = j_target;
      NPC_JR:  npc_o = jr_target_i;
      default: npc_o = pc4_if_i;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the
// IF/ID pipeline register. Branches have a delay slot, so nothing is squashed.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [1:0]             npc_sel,
  input  logic                   br_taken,
  input  logic [15:0]            imm16,
  input  logic [25:0]            imm26,
  input  logic [31:0]            jr_target,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc,
  output logic [31:0]            if_id_instr,
  output logic [31:0]            if_id_pc4,
  output logic                   if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc4_if;
  logic [31:0] npc;

  assign pc4_if = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc4_if_i    (pc4_if),
    .id_pc4_i    (pc4_q),
    .npc_sel_i   (npc_sel),
    .br_taken_i  (br_taken),
    .imm16_i     (imm16),
    .imm26_i     (imm26),
    .jr_target_i (jr_target),
    .npc_o       (npc)
  );

  // A stall holds ID too, so any redirect is re-presented once the stall drops.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stall) begin
      pc_d    = npc;
      instr_d = imem_rdata;
      pc4_d   = pc4_if;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Upper PC bits drop out, so out-of-range fetches wrap within the ROM.
  assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural ROM feeds the fetch port and
// each scenario pushes expected IF state to a scoreboard popped after every edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] jr_target;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  logic [31:0] rom [1024];
  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] jr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [9:0]  addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  if_stage #(
    .RESET_PC    (32'h0000_3000),
    .IMEM_ADDR_W (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .imm26       (imm26),
    .jr_target   (jr_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    return rom[a[11:2]];
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic stl,
                              input logic [1:0] sel, input logic bt, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] jr,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid);
    vec_t v;
    v.name = name; v.rst = rst; v.stl = stl; v.sel = sel; v.bt = bt;
    v.i16 = i16; v.i26 = i26; v.jr = jr;
    v.pc = e_pc; v.instr = e_instr; v.pc4 = e_pc4; v.valid = e_valid;
    return v;
  endfunction

  function automatic vec_t rst_vec();
    return mk("reset", 1, 0, 0, 0, 0, 0, 0, 32'h3000, 32'h0, 32'h3000, 0);
  endfunction

  // Sequential fetch from reset: k-th edge after reset.
  function automatic vec_t seq_vec(input int k);
    logic [31:0] a;
    a = 32'h3000 + 32'(4 * k);
    return mk("seq", 0, 0, 0, 0, 0, 0, 0, a + 4, rom_at(a), a + 4, 1);
  endfunction

  // Drive one vector, record its expected result, advance one edge.
  task automatic apply(input vec_t v);
    exp_t e;
    reset = v.rst; stall = v.stl; npc_sel = v.sel; br_taken = v.bt;
    imm16 = v.i16; imm26 = v.i26; jr_target = v.jr;
    e.name = v.name; e.pc = v.pc; e.addr = v.pc[11:2];
    e.instr = v.instr; e.pc4 = v.pc4; e.valid = v.valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(seq_vec(0));
    v.push_back(seq_vec(1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL reset/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    for (int k = 0; k < 4; k++) v.push_back(seq_vec(k));
    v.push_back(mk("beq_taken", 0, 0, 1, 1, 16'hFFFC, 0, 0, 32'h3000, rom_at(32'h3010),
                   32'h3014, 1));
    v.push_back(mk("beq_target", 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h3C01_1234, 32'h3004, 1));
    v.push_back(rst_vec());
    for (int k = 0; k < 4; k++) v.push_back(seq_vec(k));
    v.push_back(mk("beq_not_taken", 0, 0, 1, 0, 16'hFFFC, 0, 0, 32'h3014, rom_at(32'h3010),
                   32'h3014, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL branch/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_jump();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(seq_vec(0));
    v.push_back(seq_vec(1));
    v.push_back(mk("j", 0, 0, 2, 0, 0, 26'h000_0C10, 0, 32'h3040, rom_at(32'h3008),
                   32'h300C, 1));
    v.push_back(mk("j_target", 0, 0, 0, 0, 0, 0, 0, 32'h3044, rom_at(32'h3040), 32'h3044, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL jump/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_jr();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(mk("jr", 0, 0, 3, 0, 0, 0, 32'h3100, 32'h3100, rom_at(32'h3000), 32'h3004, 1));
    v.push_back(mk("jr_seq", 0, 0, 0, 0, 0, 0, 0, 32'h3104, rom_at(32'h3100), 32'h3104, 1));
    v.push_back(mk("jr_misalign", 0, 0, 3, 0, 0, 0, 32'h3102, 32'h3102, rom_at(32'h3104),
                   32'h3108, 1));
    v.push_back(mk("jr_misalign_seq", 0, 0, 0, 0, 0, 0, 0, 32'h3106, rom_at(32'h3102),
                   32'h3106, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL jr/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_stall();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(seq_vec(0));
    v.push_back(seq_vec(1));
    for (int k = 0; k < 3; k++)
      v.push_back(mk("stall_hold", 0, 1, 2, 0, 0, 26'h000_0C10, 0, 32'h3008, 32'h3421_5678,
                     32'h3008, 1));
    v.push_back(mk("stall_release", 0, 0, 2, 0, 0, 26'h000_0C10, 0, 32'h3040,
                   rom_at(32'h3008), 32'h300C, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL stall/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_reset_in_stall();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    for (int k = 0; k < 8; k++) v.push_back(seq_vec(k));
    v.push_back(mk("stall_3020", 0, 1, 3, 0, 0, 0, 32'h5555_0000, 32'h3020,
                   rom_at(32'h301C), 32'h3020, 1));
    v.push_back(mk("reset_in_stall", 1, 1, 3, 0, 0, 0, 32'h5555_0000, 32'h3000, 32'h0,
                   32'h3000, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL rst_stall/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(mk("jr_top", 0, 0, 3, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, rom_at(32'h3000),
                   32'h3004, 1));
    v.push_back(mk("wrap", 0, 0, 0, 0, 0, 0, 0, 32'h0, rom[1023], 32'h0, 1));
    v.push_back(mk("after_wrap", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h3C01_1234, 32'h4, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL wrap/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(rst_vec());
    v.push_back(seq_vec(0));
    v.push_back(seq_vec(1));
    v.push_back(mk("b2b_j", 0, 0, 2, 0, 0, 26'h000_0C10, 0, 32'h3040, rom_at(32'h3008),
                   32'h300C, 1));
    v.push_back(mk("b2b_jr", 0, 0, 3, 0, 0, 0, 32'h3200, 32'h3200, rom_at(32'h3040),
                   32'h3044, 1));
    v.push_back(mk("b2b_br", 0, 0, 1, 1, 16'h0004, 0, 0, 32'h3054, rom_at(32'h3200),
                   32'h3204, 1));
    v.push_back(mk("b2b_seq", 0, 0, 0, 0, 0, 0, 0, 32'h3058, rom_at(32'h3054), 32'h3058, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (pc !== e.pc || imem_addr !== e.addr || if_id_instr !== e.instr ||
          if_id_pc4 !== e.pc4 || if_id_valid !== e.valid) begin
        n_fails++;
        $display("FAIL b2b/%s[%0d]: got pc=%h addr=%h instr=%h pc4=%h v=%b, want pc=%h addr=%h instr=%h pc4=%h v=%b",
                 e.name, i, pc, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 e.pc, e.addr, e.instr, e.pc4, e.valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h2000_0000 | 32'(i);
    rom[0] = 32'h3C01_1234;
    rom[1] = 32'h3421_5678;
    reset = 1'b1; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
    imm16 = '0; imm26 = '0; jr_target = '0;
    #2;
    test_reset();
    test_branch();
    test_jump();
    test_jr();
    test_stall();
    test_reset_in_stall();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
